hazard_ctrl: RTL

Hazard and redirect controller for the five-stage pipeline. It reads the destination and control fields held by the ID/EX, EX/MEM and MEM/WB pipeline registers. From them it drives stall, flush and forwarding controls back into the PC and the pipeline registers. It also resolves branches and jumps in MEM, inserts load-use bubbles through a small state machine, and keeps saturating performance counters.

---
 rtl/hazard_ctrl.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: load-use stall, branch/jump redirect and
// operand forwarding control for the five-stage pipeline.
module hazard_ctrl #(
  parameter int LOAD_LAT = 1,
  parameter int CNT_W    = 16
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic [4:0]       id_Rs,
  input  logic [4:0]       id_Rt,
  input  logic             id_UsesRt,
  input  logic [4:0]       ex_Rs,
  input  logic [4:0]       ex_Rt,
  input  logic [4:0]       ex_Rw,
  input  logic             ex_RegWr,
  input  logic             ex_MemtoReg,
  input  logic [4:0]       mem_Rw,
  input  logic             mem_RegWr,
  input  logic             mem_MemtoReg,
  input  logic             mem_Branch,
  input  logic             mem_Zero,
  input  logic             mem_Jump,
  input  logic [4:0]       wr_Rw,
  input  logic             wr_RegWr,
  input  logic             cnt_Clr,
  output logic             pc_Stall,
  output logic             if_id_Stall,
  output logic             id_ex_Flush,
  output logic             if_id_Flush,
  output logic             ex_mem_Flush,
  output logic             pc_Sel,
  output logic [1:0]       ForwardA,
  output logic [1:0]       ForwardB,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic {RUN, STALL} state_t;

  localparam logic [1:0] LAT_M1 = 2'(LOAD_LAT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           r_state;
  state_t           w_state_n;
  logic [1:0]       r_left;
  logic [1:0]       w_left_n;
  logic             w_load_use;
  logic             w_redirect;
  logic             w_stall;
  logic             w_redir;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  // Loaded value in EX feeds a source of the instruction in ID.
  assign w_load_use = ex_MemtoReg & ex_RegWr & (ex_Rw != 5'd0) &
                      ((ex_Rw == id_Rs) |
                       (id_UsesRt & (ex_Rw == id_Rt)));

  assign w_redirect = (mem_Branch & mem_Zero) | mem_Jump;

  // Forward source: ALU result in MEM first, then WB data.
  function automatic logic [1:0] fwd(input logic [4:0] src);
    logic [1:0] sel;
    sel = 2'b00;
    if (mem_RegWr & !mem_MemtoReg &
        (mem_Rw != 5'd0) & (mem_Rw == src))
      sel = 2'b10;
    else if (wr_RegWr & (wr_Rw != 5'd0) & (wr_Rw == src))
      sel = 2'b01;
    return sel;
  endfunction

  // State register and remaining-bubble counter.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_state <= RUN;
      r_left  <= 2'd0;
    end else begin
      r_state <= w_state_n;
      r_left  <= w_left_n;
    end
  end

  // Next state and stall/redirect decision; redirect always wins.
  always_comb begin
    w_state_n = r_state;
    w_left_n  = r_left;
    w_stall   = 1'b0;
    w_redir   = 1'b0;
    case (r_state)
      RUN: begin
        if (w_redirect) begin
          w_redir = 1'b1;
        end else if (w_load_use) begin
          w_stall = 1'b1;
          if (LOAD_LAT > 1) begin
            w_state_n = STALL;
            w_left_n  = LAT_M1;
          end
        end
      end
      STALL: begin
        if (w_redirect) begin
          w_redir   = 1'b1;
          w_state_n = RUN;
          w_left_n  = 2'd0;
        end else begin
          w_stall  = 1'b1;
          w_left_n = r_left - 2'd1;
          if (r_left == 2'd1)
            w_state_n = RUN;
        end
      end
      default: begin
        w_state_n = RUN;
        w_left_n  = 2'd0;
      end
    endcase
  end

  assign pc_Stall     = w_stall;
  assign if_id_Stall  = w_stall;
  assign id_ex_Flush  = w_stall | w_redir;
  assign if_id_Flush  = w_redir;
  assign ex_mem_Flush = w_redir;
  assign pc_Sel       = w_redir;
  assign ForwardA     = fwd(ex_Rs);
  assign ForwardB     = fwd(ex_Rt);

  // Saturating performance counters; clear beats increment.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (cnt_Clr)
        r_stall_cnt <= '0;
      else if (w_stall && r_stall_cnt != CNT_MAX)
        r_stall_cnt <= r_stall_cnt + 1'b1;
      if (cnt_Clr)
        r_flush_cnt <= '0;
      else if (w_redir && r_flush_cnt != CNT_MAX)
        r_flush_cnt <= r_flush_cnt + 1'b1;
    end
  end

  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;

endmodule
